// File: rtl/present_round_controller.sv
// Iterative PRESENT-80 encryption engine: one round per clock.
// Valid/ready handshakes on the job input and the ciphertext output.
module present_round_controller #(
   parameter int ROUNDS = 31
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] plaintext,
   input  logic [79:0] key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] ciphertext,
   output logic        busy,
   output logic [4:0]  round
);

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      FINAL,
      DONE
   } fsm_t;

   localparam logic [5:0] LAST = 6'(ROUNDS);

   fsm_t        fsm, fsm_d;
   logic [63:0] state_reg, state_d;
   logic [79:0] key_reg, key_d;
   logic [63:0] ct_reg, ct_d;
   logic [5:0]  rnd, rnd_d;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      unique case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         4'hF: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int n = 0; n < 16; n++)
         y[4*n +: 4] = sbox(x[4*n +: 4]);
      return y;
   endfunction

   // Bit i lands on (16*i) mod 63; bit 63 stays put.
   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 63; i++)
         y[(16*i) % 63] = x[i];
      y[63] = x[63];
      return y;
   endfunction

   function automatic logic [79:0] key_update(
      input logic [79:0] k,
      input logic [4:0]  rc
   );
      logic [79:0] r;
      r = {k[18:0], k[79:19]};
      r[79:76] = sbox(r[79:76]);
      r[19:15] = r[19:15] ^ rc;
      return r;
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fsm       <= IDLE;
         state_reg <= '0;
         key_reg   <= '0;
         ct_reg    <= '0;
         rnd       <= '0;
      end else begin
         fsm       <= fsm_d;
         state_reg <= state_d;
         key_reg   <= key_d;
         ct_reg    <= ct_d;
         rnd       <= rnd_d;
      end
   end

   always_comb begin
      fsm_d   = fsm;
      state_d = state_reg;
      key_d   = key_reg;
      ct_d    = ct_reg;
      rnd_d   = rnd;
      unique case (fsm)
         IDLE: begin
            if (in_valid) begin
               state_d = plaintext;
               key_d   = key;
               rnd_d   = 6'd1;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            state_d = p_layer(s_layer(state_reg ^ key_reg[79:16]));
            key_d   = key_update(key_reg, rnd[4:0]);
            rnd_d   = rnd + 6'd1;
            if (rnd == LAST)
               fsm_d = FINAL;
         end
         FINAL: begin
            ct_d  = state_reg ^ key_reg[79:16];
            fsm_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               rnd_d = '0;
               fsm_d = IDLE;
            end
         end
      endcase
   end

   assign in_ready   = reset_n && (fsm == IDLE);
   assign busy       = (fsm != IDLE);
   assign out_valid  = (fsm == DONE);
   assign ciphertext = ct_reg;
   assign round      = rnd[4:0];

endmodule

// File: tb/tb_present_round_controller.sv
// Scoreboard bench for present_round_controller.
// Known-answer vectors, backpressure, busy inputs, reset abort, back-to-back.
module tb_present_round_controller;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] plaintext;
   logic [79:0] key;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] ciphertext;
   logic        busy;
   logic [4:0]  round;

   localparam logic [63:0] PT0 = 64'h0;
   localparam logic [63:0] PTF = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [79:0] K0  = 80'h0;
   localparam logic [79:0] KF  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] C00 = 64'h5579C1387B228445;
   localparam logic [63:0] C0F = 64'hE72C46C0F5945049;
   localparam logic [63:0] CF0 = 64'hA112FFC72F68417B;
   localparam logic [63:0] CFF = 64'h3333DCD3213210D2;

   int          n_cmp;
   int          n_fail;
   int          cyc;
   int          hs_edge;
   int          acc_last;
   logic [63:0] exp_q[$];
   int          acc_q[$];

   present_round_controller #(.ROUNDS(31)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext),
      .busy       (busy),
      .round      (round)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [79:0] act,
                        input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each new ciphertext.
   initial begin
      logic        prev_ov;
      logic [63:0] e;
      int          a;
      prev_ov = 1'b0;
      hs_edge = -100;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            prev_ov = 1'b0;
         end else begin
            if (out_valid && !prev_ov) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_output: got %h expected none",
                           ciphertext);
               end else begin
                  e = exp_q.pop_front();
                  a = acc_q.pop_front();
                  check("ciphertext", {16'h0, ciphertext}, {16'h0, e});
                  check("latency", 80'(cyc - a), 80'd32);
               end
            end
            if (out_valid && out_ready)
               hs_edge = cyc + 1;
            prev_ov = out_valid;
         end
      end
   end

   task automatic send(input logic [63:0] pt, input logic [79:0] k,
                       input logic [63:0] e, input bit hold);
      int t;
      @(negedge clock);
      in_valid  = 1'b1;
      plaintext = pt;
      key       = k;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clock);
         t++;
      end
      if (!in_ready) begin
         check("accept_timeout", {79'h0, in_ready}, 80'd1);
      end else begin
         exp_q.push_back(e);
         acc_q.push_back(cyc + 1);
         acc_last = cyc + 1;
      end
      @(negedge clock);
      if (!hold)
         in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 200) begin
         @(negedge clock);
         t++;
      end
      check("idle_timeout", {79'h0, busy}, 80'd0);
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      while (!out_valid && t < 200) begin
         @(negedge clock);
         t++;
      end
      check("valid_timeout", {79'h0, out_valid}, 80'd1);
   endtask

   initial begin
      n_cmp     = 0;
      n_fail    = 0;
      acc_last  = 0;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      plaintext = '0;
      key       = '0;

      repeat (2) @(negedge clock);
      check("rst_out_valid", {79'h0, out_valid}, 80'd0);
      check("rst_busy", {79'h0, busy}, 80'd0);
      check("rst_round", {75'h0, round}, 80'd0);
      check("rst_ciphertext", {16'h0, ciphertext}, 80'd0);
      check("rst_in_ready", {79'h0, in_ready}, 80'd0);
      reset_n = 1'b1;
      #1;
      check("post_rst_in_ready", {79'h0, in_ready}, 80'd1);

      // Known-answer vectors
      send(PT0, K0, C00, 1'b0);
      wait_idle();
      send(PT0, KF, C0F, 1'b0);
      wait_idle();
      send(PTF, K0, CF0, 1'b0);
      wait_idle();
      send(PTF, KF, CFF, 1'b0);
      wait_idle();

      // Round counter and busy over a full job
      send(PT0, K0, C00, 1'b0);
      for (int k = 1; k <= 31; k++) begin
         check("round", {75'h0, round}, 80'(k));
         check("busy_round", {79'h0, busy}, 80'd1);
         @(negedge clock);
      end
      check("busy_final", {79'h0, busy}, 80'd1);
      wait_idle();
      check("round_idle", {75'h0, round}, 80'd0);

      // Backpressure
      out_ready = 1'b0;
      send(PT0, KF, C0F, 1'b0);
      wait_valid();
      for (int k = 0; k < 10; k++) begin
         check("bp_out_valid", {79'h0, out_valid}, 80'd1);
         check("bp_ciphertext", {16'h0, ciphertext}, {16'h0, C0F});
         check("bp_in_ready", {79'h0, in_ready}, 80'd0);
         @(negedge clock);
      end
      out_ready = 1'b1;
      @(negedge clock);
      check("bp_release_valid", {79'h0, out_valid}, 80'd0);
      check("bp_release_ready", {79'h0, in_ready}, 80'd1);
      check("bp_hold_ct", {16'h0, ciphertext}, {16'h0, C0F});

      // Inputs wiggled while busy must not disturb the job
      send(PTF, K0, CF0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         in_valid  = ~in_valid;
         plaintext = {$urandom, $urandom};
         key       = {16'(k), $urandom, $urandom};
         @(negedge clock);
      end
      in_valid = 1'b0;
      wait_idle();
      repeat (3) @(negedge clock);
      check("no_extra_job", {79'h0, busy}, 80'd0);

      // Asynchronous reset in the middle of a job
      send(PTF, KF, CFF, 1'b0);
      begin
         int t;
         t = 0;
         while (round != 5'd15 && t < 100) begin
            @(negedge clock);
            t++;
         end
      end
      check("reach_round15", {75'h0, round}, 80'd15);
      #2;
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      acc_q.delete();
      check("abort_busy", {79'h0, busy}, 80'd0);
      check("abort_round", {75'h0, round}, 80'd0);
      check("abort_out_valid", {79'h0, out_valid}, 80'd0);
      check("abort_ciphertext", {16'h0, ciphertext}, 80'd0);
      check("abort_in_ready", {79'h0, in_ready}, 80'd0);
      @(negedge clock);
      reset_n = 1'b1;
      send(PT0, K0, C00, 1'b0);
      wait_idle();

      // Back-to-back with in_valid held high
      send(PT0, K0, C00, 1'b1);
      send(PT0, KF, C0F, 1'b1);
      check("b2b_gap", 80'(acc_last - hs_edge), 80'd1);
      in_valid = 1'b0;
      wait_idle();

      repeat (5) @(negedge clock);
      check("scoreboard_empty", 80'(exp_q.size()), 80'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
